// File: rtl/vcii_bank_seq.sv
// Break-before-make sequencer for a bank of VCII cells sharing the analog pads.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   off             force bank to IDLE (priority just below rst)
//   req_valid/ready channel-select handshake; req_ch requested channel
//   settle_cyc      settle length sampled at acceptance (0 acts as 1)
//   scan_en         auto-scan enable; dwell_cyc sampled at HOLD entry (0 acts as 1)
//   bias_en, sw_en  per-cell bias enable and pass switch
//   cur_ch          selected channel; settled / busy status; err out-of-range pulse
module vcii_bank_seq #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = 8,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     off,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(NCH)-1:0]   req_ch,
    input  logic [CW-1:0]            settle_cyc,
    input  logic                     scan_en,
    input  logic [CW-1:0]            dwell_cyc,
    output logic [NCH-1:0]           bias_en,
    output logic [NCH-1:0]           sw_en,
    output logic [$clog2(NCH)-1:0]   cur_ch,
    output logic                     settled,
    output logic                     busy,
    output logic                     err
);
    localparam int unsigned CHW  = $clog2(NCH);
    localparam int unsigned DW   = $clog2(DEAD_CYC + 1);
    localparam int unsigned CNTW = (CW > DW) ? CW : DW;

    typedef enum logic [1:0] {IDLE, BREAK, SETTLE, HOLD} state_t;

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic [CW-1:0]     s_lat, s_lat_n;
    logic [CW-1:0]     dwell, dwell_n;
    logic [NCH-1:0]    bias_en_n, sw_en_n;
    logic [CHW-1:0]    cur_ch_n, nxt_ch, tgt;
    logic              settled_n, busy_n, err_n, req_ready_n;
    logic              in_range, go;

    function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] c);
        return NCH'(1) << c;
    endfunction

    assign in_range = 32'(req_ch) < NCH;
    assign nxt_ch   = (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + CHW'(1);

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        s_lat_n   = s_lat;
        dwell_n   = dwell;
        bias_en_n = bias_en;
        sw_en_n   = sw_en;
        cur_ch_n  = cur_ch;
        settled_n = settled;
        busy_n    = busy;
        err_n     = 1'b0;
        go        = 1'b0;
        tgt       = req_ch;

        case (state)
            IDLE, HOLD: begin
                // Dwell keeps running under no-op requests; expiry waits at zero
                if (state == HOLD && scan_en && dwell != '0)
                    dwell_n = dwell - CW'(1);
                if (req_valid) begin
                    if (!in_range)
                        err_n = 1'b1;
                    else if (state == IDLE || req_ch != cur_ch)
                        go = 1'b1;
                end else if (state == HOLD && scan_en && dwell == '0) begin
                    go  = 1'b1;
                    tgt = nxt_ch;
                end
            end
            BREAK: begin
                if (cnt == '0) begin
                    state_n = SETTLE;
                    sw_en_n = onehot(cur_ch);
                    cnt_n   = CNTW'(s_lat - CW'(1));
                end else begin
                    cnt_n = cnt - CNTW'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n   = HOLD;
                    settled_n = 1'b1;
                    busy_n    = 1'b0;
                    dwell_n   = (dwell_cyc == '0) ? '0 : dwell_cyc - CW'(1);
                end else begin
                    cnt_n = cnt - CNTW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Start of a switch: open all switches, power only the target cell
        if (go) begin
            state_n   = BREAK;
            cur_ch_n  = tgt;
            sw_en_n   = '0;
            bias_en_n = onehot(tgt);
            settled_n = 1'b0;
            busy_n    = 1'b1;
            s_lat_n   = (settle_cyc == '0) ? CW'(1) : settle_cyc;
            cnt_n     = CNTW'(DEAD_CYC - 1);
        end

        if (off) begin
            state_n   = IDLE;
            cnt_n     = '0;
            s_lat_n   = '0;
            dwell_n   = '0;
            bias_en_n = '0;
            sw_en_n   = '0;
            cur_ch_n  = '0;
            settled_n = 1'b0;
            busy_n    = 1'b0;
            err_n     = 1'b0;
        end

        req_ready_n = (state_n == IDLE) || (state_n == HOLD);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_lat     <= '0;
            dwell     <= '0;
            bias_en   <= '0;
            sw_en     <= '0;
            cur_ch    <= '0;
            settled   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            s_lat     <= s_lat_n;
            dwell     <= dwell_n;
            bias_en   <= bias_en_n;
            sw_en     <= sw_en_n;
            cur_ch    <= cur_ch_n;
            settled   <= settled_n;
            busy      <= busy_n;
            err       <= err_n;
            req_ready <= req_ready_n;
        end
    end
endmodule
